// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder slice.
// Contents:
//   state_e - FSM state encoding (binary): IDLE, SHIFT, DONE.
// The operand width is not defined here. It remains a parameter of the
// modules that use this package.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_8_if.sv
// serial_adder_8_if
// Request/result bundle for the bit-serial adder.
// Signals:
//   start       - request to begin an addition
//   a_in, b_in  - operands, WIDTH bits
//   cin         - carry-in
//   busy        - addition in progress
//   done        - one-cycle pulse, sum/cout valid
//   sum, cout   - registered result and carry-out
// Modports:
//   master - requester side (drives start/operands)
//   slave  - adder side (drives busy/done/results)
interface serial_adder_8_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_8_fa_cell.sv
// fa_cell
// One-bit combinational full adder. The serial adder reuses this single
// cell once per clock.
// Ports:
//   a, b, c - addend bits and carry-in
//   s       - sum bit
//   cout    - carry-out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_8.sv
// serial_adder_8
// Bit-serial adder. The operands are processed LSB first through one
// full-adder cell, one bit per clock.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - serial_adder_8_if.slave: start/a_in/b_in/cin in,
//           busy/done/sum/cout out (all outputs come from flops)
// Timing:
//   Count the accepting edge as edge 0. busy is high in cycles 1..WIDTH.
//   done pulses in cycle WIDTH+1. If start is held high, the next
//   operation is accepted one cycle later.
import serial_adder_pkg::*;

module serial_adder_8 #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_8_if.slave   bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               cell_s;
  logic               cell_c;

  fa_cell u_fa_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .c    (carry_q),
    .s    (cell_s),
    .cout (cell_c)
  );

  // busy_d and done_d are derived from the current state. As a result,
  // busy and done are each one cycle behind the state register. The
  // outputs still come straight from flops.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    busy_d  = (state_q == ST_SHIFT);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        psum_d  = {cell_s, psum_q[WIDTH-1:1]};
        carry_d = cell_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // The counter is cleared on the last bit, so it never wraps
        // in the middle of an operation.
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        sum_d   = psum_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears every register at once,
  // which also aborts an addition in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_8.sv
// tb_serial_adder_8
// Directed bench for serial_adder_8 (WIDTH=8).
// Cycle k is the interval after rising edge k, where edge 0 is the edge
// that accepts start. All outputs are sampled on the falling edge.
module tb_serial_adder_8;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [8:0] last_result;

  serial_adder_8_if #(.WIDTH(WIDTH)) bus_if ();

  serial_adder_8 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value. Record the
  // comparison and report any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present the operands with start high across exactly one rising edge
  // (edge 0). Call this task at a falling edge while the adder is idle.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus_if.a_in  = a;
    bus_if.b_in  = b;
    bus_if.cin   = c;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
  endtask

  // Run one addition and watch cycles 0..11. Busy must cover cycles 1..8,
  // done must be high only in cycle 9, and the previous result must stay
  // visible mid-operation. If inject_cycle >= 0, a competing start with
  // 0xFF+0xFF+1 is applied during that cycle, and the operands are
  // changed at the same time.
  task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int inject_cycle, input string tag);
    logic [11:0] busy_seen;
    logic [11:0] done_seen;
    logic [8:0]  expected;
    expected = {1'b0, a} + {1'b0, b} + {8'd0, c};
    applyStimulus(a, b, c);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      busy_seen[k] = bus_if.busy;
      done_seen[k] = bus_if.done;
      if (k == 5)
        checkOutput({tag, "_hold"}, {55'd0, bus_if.cout, bus_if.sum}, {55'd0, last_result});
      if (k == inject_cycle) begin
        bus_if.start = 1'b1;
        bus_if.a_in  = 8'hFF;
        bus_if.b_in  = 8'hFF;
        bus_if.cin   = 1'b1;
      end else if (k == inject_cycle + 1) begin
        bus_if.start = 1'b0;
      end
    end
    checkOutput({tag, "_busy"}, {52'd0, busy_seen}, 64'h1FE);
    checkOutput({tag, "_done"}, {52'd0, done_seen}, 64'h200);
    checkOutput({tag, "_result"}, {55'd0, bus_if.cout, bus_if.sum}, {55'd0, expected});
    last_result = expected;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] rexp;
    int         cnt;
    int         done_count;

    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a_in  = '0;
    bus_if.b_in  = '0;
    bus_if.cin   = 1'b0;
    last_result  = '0;

    #1;
    checkOutput("reset_busy", {63'd0, bus_if.busy}, 64'd0);
    checkOutput("reset_done", {63'd0, bus_if.done}, 64'd0);
    checkOutput("reset_result", {55'd0, bus_if.cout, bus_if.sum}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runOp(8'h00, 8'h00, 1'b0, -1, "zero");
    runOp(8'hFF, 8'h01, 1'b0, -1, "ff_plus_1");
    runOp(8'h7F, 8'h01, 1'b0, -1, "7f_plus_1");
    runOp(8'hA5, 8'h5A, 1'b1, -1, "ripple");
    runOp(8'h12, 8'h34, 1'b0, 4, "ignore_start");

    // Reset during cycle 5 aborts the operation and clears the result.
    applyStimulus(8'h0F, 8'h01, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {63'd0, bus_if.busy}, 64'd0);
    checkOutput("midrst_done", {63'd0, bus_if.done}, 64'd0);
    checkOutput("midrst_result", {55'd0, bus_if.cout, bus_if.sum}, 64'd0);
    last_result = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_count = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus_if.done) done_count++;
    end
    checkOutput("midrst_no_done", done_count, 64'd0);
    runOp(8'h0F, 8'h01, 1'b0, -1, "after_rst");

    // Keep start high and present new operands during each done cycle.
    // Each addition is checked against the reference sum, and the gap
    // between done pulses must be WIDTH+2 cycles.
    @(negedge clk);
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    rc = 1'($urandom_range(0, 1));
    rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
    bus_if.a_in  = ra;
    bus_if.b_in  = rb;
    bus_if.cin   = rc;
    bus_if.start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus_if.done && cnt < 20);
      checkOutput("rand_period", cnt, WIDTH + 2);
      checkOutput("rand_result", {55'd0, bus_if.cout, bus_if.sum}, {55'd0, rexp});
      if (i < 999) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rc = 1'($urandom_range(0, 1));
        rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
        bus_if.a_in = ra;
        bus_if.b_in = rb;
        bus_if.cin  = rc;
      end else begin
        bus_if.start = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
